inst_fetch: RTL
===============

# inst_fetch

Instruction-fetch stage: initiator side of the instruction-ROM read interface. Holds the program counter and drives the ROM chip-enable and address. Captures the returned instruction word into the IF/ID pipeline register. Handles pipeline stall, branch redirect, exception flush and misaligned-target detection, and sits between the instruction ROM and the decode stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `INST_NOP`, `Zero_Word, word loaded into IF/ID on bubble or flush.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_if`  in  1  hold the PC.
- `stall_id`  in  1  hold the IF/ID register.
- `branch_flag`  in  1  decode stage requests a redirect.
- `branch_addr`  in  `Inst_Addr  redirect target.
- `flush`  in  1  exception/eret flush.
- `flush_pc`  in  `Inst_Addr  flush target (exception vector or EPC).
- `rom_ce`  out  1  ROM chip-enable, `Chip_Enable / `Chip_Disable.
- `rom_addr`  out  `Inst_Addr  ROM byte address (= pc).
- `rom_inst`  in  `Inst_Data  ROM read data, combinational from `rom_ce`/`rom_addr`.
- `id_pc`  out  `Inst_Addr  IF/ID pc.
- `id_inst`  out  `Inst_Data  IF/ID instruction.
- `id_valid`  out  1  IF/ID holds a real fetched instruction.
- `id_adel`  out  1  IF/ID instruction came from a non-word-aligned pc.

## Operation
- State: `pc`, `rom_ce`, and the IF/ID register (`id_pc`, `id_inst`, `id_valid`, `id_adel`). All are registered.
- `rom_addr` = `pc`, combinational. `rom_ce` is registered.
- Reset values, asynchronous on `rst_n` low:
  - `pc`=RESET_PC, `rom_ce`=`Chip_Disable.
  - `id_pc`=0, `id_inst`=INST_NOP, `id_valid`=0, `id_adel`=0.
- Start-up sequence: `rom_ce` goes to `Chip_Enable on the first rising edge after `rst_n` deasserts. While `rom_ce` is disabled:
  - `pc` does not advance.
  - IF/ID loads bubbles.
  - The first real fetch is therefore RESET_PC.
- Next-pc priority, evaluated only when `rom_ce` is enabled:
  1. `flush` → `flush_pc`. Applies regardless of stalls.
  2. `stall_if` → hold `pc`. `branch_flag` is ignored; decode holds and re-presents it.
  3. `branch_flag` → `branch_addr`.
  4. otherwise `pc`+4, modulo 2^`Inst_Addr`. 32'hFFFF_FFFC wraps to 0.
- Delay slot: the word fetched in the cycle `branch_flag` is sampled is the delay slot. It enters IF/ID normally.
- IF/ID update:
  - `flush` → bubble: `id_inst`=INST_NOP, `id_valid`=0, `id_adel`=0, `id_pc`=0.
  - `stall_if`=1 and `stall_id`=0 → bubble.
  - `stall_id`=1 → hold all IF/ID fields.
  - otherwise → `id_pc`=`pc`, `id_valid`=1, `id_adel`=(`pc`[1:0]!=0).
    - If aligned, `id_inst`=`rom_inst`.
    - If misaligned, `id_inst`=INST_NOP. The exception is raised downstream from `id_adel`.
- Misaligned `pc` still increments by 4. The software trap flushes it away.

## Timing
- Fetch-to-decode latency is 1 cycle. The word at `pc` in cycle N is in `id_inst` in cycle N+1.
- Redirect latency:
  - A `branch_flag` sampled at edge N puts `branch_addr` on `rom_addr` in cycle N+1, as visible after that edge.
  - A `flush` behaves the same way and additionally bubbles IF/ID at edge N.
- Simultaneous events:
  - `flush` with `branch_flag` → flush wins.
  - `flush` with stalls → flush wins; `pc` and IF/ID update.
- Reset mid-operation:
  - All state returns to reset values immediately, without waiting for `clk`.
  - On release the start-up sequence repeats.
- `rst_n` is asserted asynchronously. Deassertion is synchronous to `clk`, guaranteed by the reset synchroniser upstream.

## Test plan
- Reset/start-up: hold `rst_n`=0 for 3 cycles, release, ROM word k = 32'h1000_0000+k.
  - During reset: `rom_ce`=0, `id_valid`=0.
  - Edge 1: `rom_ce`=1, `pc`=0.
  - Following edges: `id_inst` = 32'h1000_0000, then 32'h1000_0001 on consecutive cycles; `id_pc` = 0, 4, 8.
- Branch with delay slot: at `pc`=8 assert `branch_flag`, `branch_addr`=32'h40 for one cycle.
  - Required fetch sequence: 8, then 32'h40, 32'h44.
  - Word 2 (the delay slot) appears in `id_inst` with `id_valid`=1.
- Stall: at `pc`=32'h10 assert `stall_if`=1, `stall_id`=0 for 2 cycles.
  - `pc` stays 32'h10.
  - IF/ID shows 2 bubbles (`id_valid`=0, `id_inst`=0).
  - With both stalls high, IF/ID holds its last value.
  - A `branch_flag` asserted during the stall does not change `pc`.
- Flush priority: assert `flush`=1, `flush_pc`=32'h180, with `stall_if`=`stall_id`=`branch_flag`=1.
  - Next cycle: `rom_addr`=32'h180, `id_valid`=0.
- Misalignment and wrap:
  - Branch to 32'h42 → `id_adel`=1, `id_pc`=32'h42, `id_inst`=0.
  - Flush to 32'hFFFF_FFFC → next fetch `pc`=0.
- Async reset mid-stream: drop `rst_n` between edges while `pc`=32'h20.
  - Outputs reach reset values before the next edge.
  - Restart fetches RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and loads the IF/ID register.
// Redirect priority is flush > stall_if > branch > sequential.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_if,
   input  logic        stall_id,
   input  logic        branch_flag,
   input  logic [31:0] branch_addr,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        rom_ce,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        id_adel
);

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   logic [31:0] pc_q, pc_d;
   logic        rom_ce_q, rom_ce_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d;
   logic        id_adel_q, id_adel_d;
   logic        misaligned;

   assign misaligned = (pc_q[1:0] != 2'b00);

   always_comb begin
      pc_d       = pc_q;
      rom_ce_d   = CHIP_ENABLE;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
      id_adel_d  = id_adel_q;

      if (rom_ce_q == CHIP_DISABLE) begin
         id_pc_d    = 32'h0;
         id_inst_d  = INST_NOP;
         id_valid_d = 1'b0;
         id_adel_d  = 1'b0;
      end else begin
         if (flush)
            pc_d = flush_pc;
         else if (stall_if)
            pc_d = pc_q;
         else if (branch_flag)
            pc_d = branch_addr;
         else
            pc_d = pc_q + 32'd4;

         // flush bubbles even under stall_id; stall_id otherwise freezes IF/ID
         if (flush || (stall_if && !stall_id)) begin
            id_pc_d    = 32'h0;
            id_inst_d  = INST_NOP;
            id_valid_d = 1'b0;
            id_adel_d  = 1'b0;
         end else if (!stall_id) begin
            id_pc_d    = pc_q;
            id_inst_d  = misaligned ? INST_NOP : rom_inst;
            id_valid_d = 1'b1;
            id_adel_d  = misaligned;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         rom_ce_q   <= CHIP_DISABLE;
         id_pc_q    <= 32'h0;
         id_inst_q  <= INST_NOP;
         id_valid_q <= 1'b0;
         id_adel_q  <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         rom_ce_q   <= rom_ce_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
         id_adel_q  <= id_adel_d;
      end
   end

   assign rom_ce   = rom_ce_q;
   assign rom_addr = pc_q;
   assign id_pc    = id_pc_q;
   assign id_inst  = id_inst_q;
   assign id_valid = id_valid_q;
   assign id_adel  = id_adel_q;

endmodule
